// File: rtl/conv_stream_sequencer.sv
// Job sequencer for the 5x5 filter core: splits one byte stream into a kernel phase and an
// image phase, forwards bytes to the core, then counts core results until the frame completes.
module conv_stream_sequencer #(
  parameter int unsigned IMG_W       = 512,
  parameter int unsigned IMG_H       = 512,
  parameter int unsigned KLEN        = 25,
  parameter int unsigned EXP_RESULTS = (IMG_W - 4) * (IMG_H - 4),
  parameter int unsigned DRAIN_TO    = 1024,
  parameter int unsigned CNT_W       = 20
) (
  input  logic             axi_clk,
  input  logic             axi_reset_n,
  input  logic             i_start,
  input  logic             i_reload_kernel,
  input  logic             s_tvalid,
  input  logic [7:0]       s_tdata,
  input  logic             s_tlast,
  output logic             s_tready,
  output logic [7:0]       o_core_data,
  output logic             o_core_data_valid,
  output logic             o_core_kernel_mode,
  output logic             o_core_clr,
  input  logic             i_core_result_valid,
  output logic             o_busy,
  output logic             o_done,
  output logic [3:0]       o_err,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_pix_count,
  output logic [CNT_W-1:0] o_res_count
);

  localparam int unsigned KW = $clog2(KLEN + 1);
  localparam int unsigned IW = $clog2(DRAIN_TO + 1);

  localparam logic [CNT_W-1:0] LastPix = CNT_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0] ExpRes  = CNT_W'(EXP_RESULTS);
  localparam logic [KW-1:0]    LastK   = KW'(KLEN - 1);
  localparam logic [IW-1:0]    IdleMax = IW'(DRAIN_TO);

  typedef enum logic [2:0] {
    StIdle,
    StKload,
    StStream,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic             kvalid_q, kvalid_d;
  logic [KW-1:0]    k_idx_q, k_idx_d;
  logic [CNT_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] res_q, res_d;
  logic [IW-1:0]    idle_q, idle_d;
  logic [3:0]       err_q, err_d, err_set;
  logic             clr_q, clr_d;
  logic [7:0]       core_data_q;
  logic             core_valid_q;
  logic             core_kmode_q;

  logic xfer;
  logic res_inc;

  assign s_tready = (state_q == StKload) || (state_q == StStream);
  assign xfer     = s_tvalid & s_tready;

  // Results only count while a frame is streaming or draining; saturate at all-ones.
  assign res_inc = i_core_result_valid &&
                   ((state_q == StStream) || (state_q == StDrain)) &&
                   (res_q != '1);

  always_comb begin
    state_d  = state_q;
    kvalid_d = kvalid_q;
    k_idx_d  = k_idx_q;
    pix_d    = pix_q;
    res_d    = res_q;
    idle_d   = idle_q;
    err_set  = '0;
    clr_d    = 1'b0;

    if (res_inc) begin
      res_d = res_q + CNT_W'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          clr_d   = 1'b1;
          pix_d   = '0;
          res_d   = '0;
          k_idx_d = '0;
          idle_d  = '0;
          state_d = (i_reload_kernel || !kvalid_q) ? StKload : StStream;
        end
      end

      StKload: begin
        if (xfer) begin
          if (s_tlast) begin
            // Truncated kernel: the coefficients held by the core are now unusable.
            err_set[2] = 1'b1;
            kvalid_d   = 1'b0;
            state_d    = StIdle;
          end else if (k_idx_q == LastK) begin
            kvalid_d = 1'b1;
            state_d  = StStream;
          end else begin
            k_idx_d = k_idx_q + KW'(1);
          end
        end
      end

      StStream: begin
        idle_d = '0;
        if (xfer) begin
          pix_d = pix_q + CNT_W'(1);
          if (pix_q == LastPix) begin
            if (!s_tlast) begin
              err_set[1] = 1'b1;
            end
            state_d = StDrain;
          end else if (s_tlast) begin
            err_set[0] = 1'b1;
            state_d    = StDrain;
          end
        end
      end

      StDrain: begin
        if (i_core_result_valid) begin
          idle_d = '0;
        end else if (idle_q != IdleMax) begin
          idle_d = idle_q + IW'(1);
        end
        if (res_q == ExpRes) begin
          state_d = StDone;
        end else if (idle_q == IdleMax) begin
          err_set[3] = 1'b1;
          state_d    = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // A new error in the same cycle as the clear request survives.
    err_d = (i_err_clr ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q  <= StIdle;
      kvalid_q <= 1'b0;
      k_idx_q  <= '0;
      pix_q    <= '0;
      res_q    <= '0;
      idle_q   <= '0;
      err_q    <= '0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      kvalid_q <= kvalid_d;
      k_idx_q  <= k_idx_d;
      pix_q    <= pix_d;
      res_q    <= res_d;
      idle_q   <= idle_d;
      err_q    <= err_d;
      clr_q    <= clr_d;
    end
  end

  // Core-facing byte path: one register stage after the handshake.
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      core_data_q  <= '0;
      core_valid_q <= 1'b0;
      core_kmode_q <= 1'b0;
    end else begin
      core_valid_q <= xfer;
      core_kmode_q <= xfer && (state_q == StKload);
      if (xfer) begin
        core_data_q <= s_tdata;
      end
    end
  end

  assign o_core_data        = core_data_q;
  assign o_core_data_valid  = core_valid_q;
  assign o_core_kernel_mode = core_kmode_q;
  assign o_core_clr         = clr_q;
  assign o_busy             = (state_q != StIdle);
  assign o_done             = (state_q == StDone);
  assign o_err              = err_q;
  assign o_pix_count        = pix_q;
  assign o_res_count        = res_q;

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// Self-checking bench for conv_stream_sequencer: byte scoreboard on the core-facing path plus
// frame-level checks of counters, error flags and done/clear pulses.
module tb_conv_stream_sequencer;

  localparam int unsigned IMG_W       = 8;
  localparam int unsigned IMG_H       = 8;
  localparam int unsigned KLEN        = 25;
  localparam int unsigned EXP_RESULTS = 16;
  localparam int unsigned DRAIN_TO    = 32;
  localparam int unsigned CNT_W       = 20;
  localparam int unsigned NPIX        = IMG_W * IMG_H;

  logic             axi_clk;
  logic             axi_reset_n;
  logic             i_start;
  logic             i_reload_kernel;
  logic             s_tvalid;
  logic [7:0]       s_tdata;
  logic             s_tlast;
  logic             s_tready;
  logic [7:0]       o_core_data;
  logic             o_core_data_valid;
  logic             o_core_kernel_mode;
  logic             o_core_clr;
  logic             i_core_result_valid;
  logic             o_busy;
  logic             o_done;
  logic [3:0]       o_err;
  logic             i_err_clr;
  logic [CNT_W-1:0] o_pix_count;
  logic [CNT_W-1:0] o_res_count;

  conv_stream_sequencer #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .KLEN       (KLEN),
    .EXP_RESULTS(EXP_RESULTS),
    .DRAIN_TO   (DRAIN_TO),
    .CNT_W      (CNT_W)
  ) dut (
    .axi_clk            (axi_clk),
    .axi_reset_n        (axi_reset_n),
    .i_start            (i_start),
    .i_reload_kernel    (i_reload_kernel),
    .s_tvalid           (s_tvalid),
    .s_tdata            (s_tdata),
    .s_tlast            (s_tlast),
    .s_tready           (s_tready),
    .o_core_data        (o_core_data),
    .o_core_data_valid  (o_core_data_valid),
    .o_core_kernel_mode (o_core_kernel_mode),
    .o_core_clr         (o_core_clr),
    .i_core_result_valid(i_core_result_valid),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err),
    .i_err_clr          (i_err_clr),
    .o_pix_count        (o_pix_count),
    .o_res_count        (o_res_count)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Expected {kernel_mode, data} for every byte accepted by the DUT.
  logic [8:0] sb_q[$];

  int   km_cnt = 0;
  int   px_cnt = 0;
  int   clr_cnt = 0;
  int   done_cnt = 0;
  logic first_pending = 1'b0;
  logic first_km = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and observe the core-facing outputs there.
  task automatic tick();
    logic [8:0] exp;
    @(negedge axi_clk);
    if (o_core_clr) clr_cnt++;
    if (o_done) done_cnt++;
    if (o_core_data_valid) begin
      if (o_core_kernel_mode) km_cnt++;
      else px_cnt++;
      if (first_pending) begin
        first_km      = o_core_kernel_mode;
        first_pending = 1'b0;
      end
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        check_eq("core_byte", {23'd0, o_core_kernel_mode, o_core_data}, {23'd0, exp});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start_job(input logic reload);
    i_start         = 1'b1;
    i_reload_kernel = reload;
    tick();
    i_start         = 1'b0;
    i_reload_kernel = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic km);
    int n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    while (!s_tready && n < 50) begin
      tick();
      n++;
    end
    if (s_tready) sb_q.push_back({km, d});
    else check_eq("tready_timeout", 32'(s_tready), 1);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_kernel(input int seed);
    logic [7:0] d;
    for (int k = 0; k < int'(KLEN); k++) begin
      d = 8'(k * 7 + seed);
      send_byte(d, 1'b0, 1'b1);
    end
  endtask

  task automatic send_pixels(input int n, input int last_at, input int seed, input int gapmax);
    logic [7:0] d;
    for (int p = 0; p < n; p++) begin
      if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
      d = 8'(p * 3 + seed);
      send_byte(d, p == last_at, 1'b0);
    end
  endtask

  task automatic send_results(input int n);
    for (int r = 0; r < n; r++) begin
      i_core_result_valid = 1'b1;
      tick();
    end
    i_core_result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    int d0 = done_cnt;
    cycles = 0;
    while (done_cnt == d0 && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq("done_pulse", 32'(done_cnt - d0), 1);
  endtask

  task automatic check_outputs_zero();
    check_eq("rst_tready", 32'(s_tready), 0);
    check_eq("rst_cdata", 32'(o_core_data), 0);
    check_eq("rst_cvalid", 32'(o_core_data_valid), 0);
    check_eq("rst_kmode", 32'(o_core_kernel_mode), 0);
    check_eq("rst_clr", 32'(o_core_clr), 0);
    check_eq("rst_busy", 32'(o_busy), 0);
    check_eq("rst_done", 32'(o_done), 0);
    check_eq("rst_err", 32'(o_err), 0);
    check_eq("rst_pix", 32'(o_pix_count), 0);
    check_eq("rst_res", 32'(o_res_count), 0);
  endtask

  task automatic clear_err();
    i_err_clr = 1'b1;
    tick();
    i_err_clr = 1'b0;
    check_eq("err_cleared", 32'(o_err), 0);
  endtask

  int km0, px0, clr0, cyc;

  initial begin
    axi_reset_n         = 1'b1;
    i_start             = 1'b0;
    i_reload_kernel     = 1'b0;
    s_tvalid            = 1'b0;
    s_tdata             = 8'h00;
    s_tlast             = 1'b0;
    i_core_result_valid = 1'b0;
    i_err_clr           = 1'b0;
    #2 axi_reset_n = 1'b0;
    #1 check_outputs_zero();
    idle(3);
    axi_reset_n = 1'b1;
    idle(2);

    // Case 1: full job with kernel reload.
    km0 = km_cnt; px0 = px_cnt; clr0 = clr_cnt;
    start_job(1'b1);
    send_kernel(3);
    send_pixels(NPIX, NPIX - 1, 1, 0);
    check_eq("c1_tready_drain", 32'(s_tready), 0);
    send_results(EXP_RESULTS);
    wait_done(40, cyc);
    tick();
    check_eq("c1_km_valids", 32'(km_cnt - km0), KLEN);
    check_eq("c1_px_valids", 32'(px_cnt - px0), NPIX);
    check_eq("c1_clr", 32'(clr_cnt - clr0), 1);
    check_eq("c1_pix_count", 32'(o_pix_count), NPIX);
    check_eq("c1_res_count", 32'(o_res_count), EXP_RESULTS);
    check_eq("c1_err", 32'(o_err), 0);
    check_eq("c1_busy", 32'(o_busy), 0);
    check_eq("c1_sb_drained", 32'(sb_q.size()), 0);

    // Case 2: reuse the loaded kernel.
    km0 = km_cnt; px0 = px_cnt; clr0 = clr_cnt;
    first_pending = 1'b1;
    start_job(1'b0);
    send_pixels(NPIX, NPIX - 1, 5, 0);
    send_results(EXP_RESULTS);
    wait_done(40, cyc);
    tick();
    check_eq("c2_first_kmode", 32'(first_km), 0);
    check_eq("c2_km_valids", 32'(km_cnt - km0), 0);
    check_eq("c2_px_valids", 32'(px_cnt - px0), NPIX);
    check_eq("c2_clr", 32'(clr_cnt - clr0), 1);
    check_eq("c2_err", 32'(o_err), 0);

    // Case 3: early tlast on pixel index 40.
    start_job(1'b0);
    send_pixels(41, 40, 9, 0);
    check_eq("c3_tready", 32'(s_tready), 0);
    check_eq("c3_busy", 32'(o_busy), 1);
    check_eq("c3_err", 32'(o_err), 32'h1);
    check_eq("c3_pix_count", 32'(o_pix_count), 41);
    send_results(EXP_RESULTS);
    wait_done(40, cyc);
    tick();
    clear_err();

    // Case 4: missing tlast and too few results -> timeout.
    start_job(1'b0);
    send_pixels(NPIX, -1, 2, 0);
    check_eq("c4_err_notlast", 32'(o_err), 32'h2);
    send_results(10);
    wait_done(DRAIN_TO + 20, cyc);
    check_eq("c4_timeout_window", 32'((cyc >= int'(DRAIN_TO)) && (cyc <= int'(DRAIN_TO) + 2)), 1);
    check_eq("c4_err_timeout", 32'(o_err), 32'hA);
    check_eq("c4_res_count", 32'(o_res_count), 10);
    tick();
    clear_err();

    // Case 5: gaps, a start while busy, and reset mid-stream.
    km0 = km_cnt; clr0 = clr_cnt;
    start_job(1'b0);
    for (int p = 0; p < 30; p++) begin
      idle(int'($urandom_range(0, 3)));
      if (p == 10) begin
        i_start = 1'b1; i_reload_kernel = 1'b1;
        tick();
        i_start = 1'b0; i_reload_kernel = 1'b0;
      end
      send_byte(8'(p * 11 + 4), 1'b0, 1'b0);
    end
    check_eq("c5_clr_once", 32'(clr_cnt - clr0), 1);
    check_eq("c5_no_kload", 32'(km_cnt - km0), 0);
    check_eq("c5_pix_count", 32'(o_pix_count), 30);
    #3 axi_reset_n = 1'b0;
    #1 check_outputs_zero();
    idle(2);
    sb_q.delete();
    axi_reset_n = 1'b1;
    tick();
    km0 = km_cnt;
    start_job(1'b0);
    send_kernel(6);
    send_pixels(NPIX, NPIX - 1, 7, 2);
    send_results(EXP_RESULTS);
    wait_done(40, cyc);
    tick();
    check_eq("c5_reload_after_reset", 32'(km_cnt - km0), KLEN);
    check_eq("c5_err", 32'(o_err), 0);
    check_eq("c5_pix_final", 32'(o_pix_count), NPIX);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
